// File: rtl/pixel_shift_sequencer_pkg.sv
// Shared types for the pixel shift sequencer: shift-register mode encodings,
// the two FSM state sets and the buffered cell record.
package pixel_shift_sequencer_pkg;

  localparam int         DATA_W   = 24;
  localparam logic [2:0] PIX_LAST = 3'd7;

  // Values are the {S1,S0} pins of the external universal shift registers.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } sr_mode_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_FULL
  } fetch_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } shift_state_e;

  typedef struct packed {
    logic              flip;
    logic [DATA_W-1:0] planes;
  } cell_t;

endpackage

// File: rtl/cell_fetch_buffer.sv
// Cell fetch FSM: requests one cell at a time from the pattern ROM and keeps it
// in a single-entry buffer until the shifter consumes it.
module cell_fetch_buffer
  import pixel_shift_sequencer_pkg::*;
#(
  parameter int CELLS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk1,
  input  logic              n_clr1,
  input  logic              restart,
  input  logic              consume,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_flip,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              buf_full,
  output cell_t             buf_cell
);

  localparam int             CNT_W   = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  fetch_state_e      f_q, f_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  fetched_q, fetched_d;
  cell_t             cell_q, cell_d;

  always_comb begin
    // NOTE: every _d starts from its held value so no branch can infer a latch.
    f_d       = f_q;
    addr_d    = addr_q;
    fetched_d = fetched_q;
    cell_d    = cell_q;
    if (restart) begin
      f_d       = F_REQ;
      addr_d    = '0;
      fetched_d = '0;
    end else begin
      case (f_q)
        F_REQ: begin
          // Acks in any other state fall through untouched.
          if (rom_ack) begin
            f_d         = F_FULL;
            cell_d.flip   = rom_flip;
            cell_d.planes = rom_data;
            addr_d      = addr_q + ADDR_W'(1);
            fetched_d   = fetched_q + CNT_W'(1);
          end
        end
        F_FULL: begin
          if (consume) f_d = (fetched_q == CELLS_C) ? F_IDLE : F_REQ;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1 or negedge n_clr1) begin
    if (!n_clr1) begin
      f_q       <= F_IDLE;
      addr_q    <= '0;
      fetched_q <= '0;
    end else begin
      f_q       <= f_d;
      addr_q    <= addr_d;
      fetched_q <= fetched_d;
    end
  end

  // NOTE: the payload has no reset; it is only observed while f_q == F_FULL.
  always_ff @(posedge clk1) begin
    cell_q <= cell_d;
  end

  assign rom_req  = (f_q == F_REQ);
  assign rom_addr = addr_q;
  assign buf_full = (f_q == F_FULL);
  assign buf_cell = cell_q;

endmodule

// File: rtl/pixel_shift_sequencer.sv
// Pixel shift sequencer: drives the load/shift/clear controls of the external
// bit-plane shift registers, one 8-pixel cell at a time, from the fetch buffer.
module pixel_shift_sequencer
  import pixel_shift_sequencer_pkg::*;
#(
  parameter int CELLS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk1,
  input  logic              n_clr1,
  input  logic              line_start,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_flip,
  output logic [DATA_W-1:0] sr_data,
  output logic              sr_s1,
  output logic              sr_s0,
  output logic              sr_pe_n,
  output logic              sr_clr_n,
  output logic              busy,
  output logic              line_done,
  output logic              underrun
);

  localparam int               CNT_W   = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  logic  buf_full;
  cell_t buf_cell;
  logic  load_now;

  cell_fetch_buffer #(
    .CELLS  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_fetch (
    .clk1     (clk1),
    .n_clr1   (n_clr1),
    .restart  (line_start),
    .consume  (load_now),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .rom_flip (rom_flip),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .buf_full (buf_full),
    .buf_cell (buf_cell)
  );

  shift_state_e      s_q, s_d;
  logic [2:0]        pix_q, pix_d;
  logic [CNT_W-1:0]  loaded_q, loaded_d;
  logic              cur_flip_q, cur_flip_d;
  logic              stall_q, stall_d;
  logic              underrun_q, underrun_d;
  logic              busy_q, busy_d;
  sr_mode_e          mode_q, mode_d;
  logic [DATA_W-1:0] sr_data_q, sr_data_d;
  logic              sr_clr_n_q, sr_clr_n_d;
  logic              line_done_q, line_done_d;

  // pix_q is the pixel whose control word is decided this cycle and shown next.
  always_comb begin
    s_d         = s_q;
    pix_d       = pix_q;
    loaded_d    = loaded_q;
    cur_flip_d  = cur_flip_q;
    stall_d     = stall_q;
    underrun_d  = underrun_q;
    busy_d      = busy_q;
    mode_d      = HOLD;
    sr_data_d   = sr_data_q;
    sr_clr_n_d  = 1'b1;
    line_done_d = 1'b0;
    load_now    = 1'b0;
    if (line_start) begin
      s_d        = S_PRIME;
      pix_d      = '0;
      loaded_d   = '0;
      stall_d    = 1'b0;
      underrun_d = 1'b0;
      busy_d     = 1'b1;
      sr_clr_n_d = ~busy_q;
    end else begin
      if (line_done_q) busy_d = 1'b0;
      case (s_q)
        S_PRIME: load_now = buf_full;
        S_RUN: begin
          if (pix_q != PIX_LAST) begin
            mode_d = cur_flip_q ? SHR : SHL;
            pix_d  = pix_q + 3'd1;
          end else if (loaded_q == CELLS_C) begin
            line_done_d = 1'b1;
            s_d         = S_IDLE;
            pix_d       = '0;
          end else if (buf_full) begin
            load_now = 1'b1;
          end else begin
            // Starved: park at pix 7, clear the registers once, wait for data.
            underrun_d = 1'b1;
            stall_d    = 1'b1;
            sr_clr_n_d = stall_q;
          end
        end
        default: ;
      endcase
      if (load_now) begin
        mode_d     = LOAD;
        sr_data_d  = buf_cell.planes;
        cur_flip_d = buf_cell.flip;
        loaded_d   = loaded_q + CNT_W'(1);
        pix_d      = '0;
        s_d        = S_RUN;
        stall_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk1 or negedge n_clr1) begin
    if (!n_clr1) begin
      s_q         <= S_IDLE;
      pix_q       <= '0;
      loaded_q    <= '0;
      cur_flip_q  <= 1'b0;
      stall_q     <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= HOLD;
      sr_data_q   <= '0;
      sr_clr_n_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      pix_q       <= pix_d;
      loaded_q    <= loaded_d;
      cur_flip_q  <= cur_flip_d;
      stall_q     <= stall_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      sr_data_q   <= sr_data_d;
      sr_clr_n_q  <= sr_clr_n_d;
      line_done_q <= line_done_d;
    end
  end

  assign sr_s1     = mode_q[1];
  assign sr_s0     = mode_q[0];
  assign sr_pe_n   = ~(mode_q[1] & mode_q[0]);
  assign sr_data   = sr_data_q;
  assign sr_clr_n  = sr_clr_n_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_pixel_shift_sequencer.sv
// Scoreboard bench: each line start queues the cells the ROM will return; a
// monitor pops one entry per observed load and checks data, modes and spacing.
module tb_pixel_shift_sequencer;

  localparam int CELLS  = 4;
  localparam int ADDR_W = 5;

  logic              clk1 = 1'b0;
  logic              n_clr1;
  logic              line_start;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [23:0]       rom_data;
  logic              rom_flip;
  logic [23:0]       sr_data;
  logic              sr_s1, sr_s0, sr_pe_n, sr_clr_n;
  logic              busy, line_done, underrun;

  pixel_shift_sequencer #(
    .CELLS  (CELLS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk1       (clk1),
    .n_clr1     (n_clr1),
    .line_start (line_start),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .rom_flip   (rom_flip),
    .sr_data    (sr_data),
    .sr_s1      (sr_s1),
    .sr_s0      (sr_s0),
    .sr_pe_n    (sr_pe_n),
    .sr_clr_n   (sr_clr_n),
    .busy       (busy),
    .line_done  (line_done),
    .underrun   (underrun)
  );

  initial forever #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  // ROM image for the current line ({flip, planes}) and the expected load order.
  logic [24:0] rom_mem [0:31];
  logic [24:0] exp_q [$];

  int dly_min = 2;
  int dly_max = 2;
  bit slow_mode = 1'b0;

  int cyc = 0;
  int done_cnt = 0;
  int loads_in_line, shifts_since, clr_pulses, last_load_cyc;
  bit have_prev, cur_flip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM model: answers a request after the chosen delay, sprays stray acks otherwise.
  initial begin
    int wait_cnt;
    int cur_dly;
    wait_cnt = 0;
    cur_dly  = 2;
    rom_ack  = 1'b0;
    rom_data = '0;
    rom_flip = 1'b0;
    forever begin
      @(negedge clk1);
      rom_ack = 1'b0;
      if (!n_clr1) begin
        rom_ack = 1'b1;
        {rom_flip, rom_data} = 25'($urandom);
        wait_cnt = 0;
      end else if (rom_req) begin
        if (wait_cnt >= cur_dly) begin
          rom_ack = 1'b1;
          {rom_flip, rom_data} = rom_mem[rom_addr];
          wait_cnt = 0;
          cur_dly = $urandom_range(dly_max, dly_min);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if ($urandom_range(5, 0) == 0) begin
          rom_ack = 1'b1;
          {rom_flip, rom_data} = 25'($urandom);
        end
      end
    end
  end

  // Monitor: compares every presented control word against the scoreboard.
  initial begin
    logic [1:0]        m;
    logic [24:0]       e;
    logic              prev_req;
    logic [ADDR_W-1:0] prev_addr;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk1);
      #1;
      cyc++;
      if (n_clr1) begin
        m = {sr_s1, sr_s0};
        if (prev_req && rom_req && !line_start) check("addr_stable", 32'(rom_addr), 32'(prev_addr));
        prev_req  = rom_req;
        prev_addr = rom_addr;
        if (!sr_clr_n) clr_pulses++;
        if (m == 2'b11) begin
          check("load_pe_n", 32'(sr_pe_n), 32'd0);
          check("load_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("load_data", 32'(sr_data), 32'(e[23:0]));
            cur_flip = e[24];
          end
          if (have_prev) begin
            check("shifts_per_cell", shifts_since, 7);
            if (slow_mode) check("gap_stretched", 32'((cyc - last_load_cyc) > 8), 32'd1);
            else           check("load_gap", cyc - last_load_cyc, 8);
          end
          have_prev     = 1'b1;
          last_load_cyc = cyc;
          shifts_since  = 0;
          loads_in_line++;
        end else if (m != 2'b00) begin
          check("shift_mode", 32'(m), cur_flip ? 32'd2 : 32'd1);
          check("shift_pe_n", 32'(sr_pe_n), 32'd1);
          shifts_since++;
        end
        if (line_done) begin
          done_cnt++;
          check("done_all_loaded", exp_q.size(), 0);
          check("done_shifts", shifts_since, 7);
          check("done_busy", 32'(busy), 32'd1);
        end
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  // Issue a line start (called just after a negedge) with a fresh ROM image.
  task automatic start_line(input bit directed);
    for (int i = 0; i < 32; i++) rom_mem[i] = {1'($urandom_range(1, 0)), 24'($urandom)};
    if (directed) begin
      rom_mem[0][24] = 1'b0;
      rom_mem[1]     = {1'b1, 24'hA5C33C};
      rom_mem[2][24] = 1'b0;
    end
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) exp_q.push_back(rom_mem[i]);
    line_start = 1'b1;
    @(negedge clk1);
    line_start    = 1'b0;
    loads_in_line = 0;
    shifts_since  = 0;
    clr_pulses    = 0;
    have_prev     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk1);
      n++;
    end
    check({name, "_done_seen"}, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic end_line(input string name, input bit exp_underrun);
    check({name, "_loads"}, loads_in_line, CELLS);
    check({name, "_underrun"}, 32'(underrun), 32'(exp_underrun));
    if (exp_underrun) check({name, "_clr_pulse"}, 32'(clr_pulses > 0), 32'd1);
    else              check({name, "_no_clr"}, clr_pulses, 0);
    @(negedge clk1);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    check({name, "_done_single"}, 32'(line_done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rom_req"}, 32'(rom_req), 32'd0);
    check({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({name, "_mode"}, 32'({sr_s1, sr_s0}), 32'd0);
    check({name, "_pe_n"}, 32'(sr_pe_n), 32'd1);
    check({name, "_clr_n"}, 32'(sr_clr_n), 32'd0);
    check({name, "_sr_data"}, 32'(sr_data), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(line_done), 32'd0);
    check({name, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    int n;
    int done_before;
    n_clr1     = 1'b0;
    line_start = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk1);
    n_clr1 = 1'b1;
    @(negedge clk1);
    check("post_rst_clr_n", 32'(sr_clr_n), 32'd1);
    check("post_rst_idle", 32'(rom_req | busy), 32'd0);

    // Directed line with a flipped cell 1.
    dly_min = 2; dly_max = 2;
    start_line(1'b1);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("basic", 200);
    end_line("basic", 1'b0);

    // Random content and ack delays that still keep up with the shifter.
    for (int l = 0; l < 6; l++) begin
      dly_min = 0; dly_max = 6;
      start_line(1'b0);
      wait_done("rand", 200);
      end_line("rand", 1'b0);
    end

    // ROM too slow to keep up.
    dly_min = 12; dly_max = 12; slow_mode = 1'b1;
    start_line(1'b0);
    wait_done("slow", 600);
    end_line("slow", 1'b1);
    slow_mode = 1'b0;

    // Restart in the middle of cell 2.
    dly_min = 2; dly_max = 2;
    start_line(1'b0);
    n = 0;
    while (!(loads_in_line == 3 && shifts_since == 3) && n < 200) begin
      @(negedge clk1);
      n++;
    end
    check("restart_point_reached", 32'(n < 200), 32'd1);
    done_before = done_cnt;
    start_line(1'b0);
    check("restart_addr", 32'(rom_addr), 32'd0);
    check("restart_req", 32'(rom_req), 32'd1);
    check("restart_clr_n", 32'(sr_clr_n), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_no_done", done_cnt, done_before);
    @(negedge clk1);
    check("restart_clr_one_cycle", 32'(sr_clr_n), 32'd1);
    wait_done("restart", 200);
    end_line("restart", 1'b0);

    // Asynchronous reset between edges in mid-line; stray acks during reset.
    start_line(1'b0);
    repeat (12) @(negedge clk1);
    @(posedge clk1);
    #2;
    n_clr1 = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(negedge clk1);
    n_clr1 = 1'b1;
    @(negedge clk1);
    check("rst_ack_ignored_req", 32'(rom_req), 32'd0);
    check("rst_ack_ignored_busy", 32'(busy), 32'd0);
    check("rst_release_clr_n", 32'(sr_clr_n), 32'd1);
    start_line(1'b0);
    wait_done("post_reset", 200);
    end_line("post_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
